// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin grant, one outstanding access,
// bounded wait on mem_ready with a timeout fault returned to the requester.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        r0_req,
    input  logic        r0_is_write,
    input  logic        r0_is_unsigned,
    input  logic [1:0]  r0_op,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_ack,
    output logic [31:0] r0_rdata,
    output logic [2:0]  r0_fault,
    input  logic        r1_req,
    input  logic        r1_is_write,
    input  logic        r1_is_unsigned,
    input  logic [1:0]  r1_op,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_ack,
    output logic [31:0] r1_rdata,
    output logic [2:0]  r1_fault,
    output logic        mem_enable_n,
    output logic        mem_is_write,
    output logic        mem_is_unsigned,
    output logic [1:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out,
    input  logic        mem_ready,
    input  logic        mem_op_fault,
    input  logic        mem_addr_fault,
    input  logic        mem_access_fault_n
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic        grant_reg;
    logic        last_grant_reg;
    logic        cmd_is_write_reg;
    logic        cmd_is_unsigned_reg;
    logic [1:0]  cmd_op_reg;
    logic [31:0] cmd_addr_reg;
    logic [31:0] cmd_wdata_reg;
    logic [31:0] rdata_reg;
    logic [2:0]  fault_reg;
    logic [7:0]  count_reg;
    logic        winner;
    logic        any_req;
    logic        timeout_hit;
    logic        ack_vec   [2];
    logic [31:0] rdata_vec [2];
    logic [2:0]  fault_vec [2];

    assign any_req     = r0_req | r1_req;
    assign timeout_hit = (count_reg == TIMEOUT_LAST);

    // On a tie the requester not served last wins; otherwise the lone requester.
    always_comb begin
        winner = r1_req;
        if (r0_req && r1_req) begin
            winner = ~last_grant_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  if (mem_ready || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_reg           <= 1'b0;
            last_grant_reg      <= 1'b1;
            cmd_is_write_reg    <= 1'b0;
            cmd_is_unsigned_reg <= 1'b0;
            cmd_op_reg          <= 2'b00;
            cmd_addr_reg        <= 32'h0;
            cmd_wdata_reg       <= 32'h0;
            rdata_reg           <= 32'h0;
            fault_reg           <= 3'b000;
            count_reg           <= 8'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_reg           <= winner;
                        cmd_is_write_reg    <= winner ? r1_is_write    : r0_is_write;
                        cmd_is_unsigned_reg <= winner ? r1_is_unsigned : r0_is_unsigned;
                        cmd_op_reg          <= winner ? r1_op          : r0_op;
                        cmd_addr_reg        <= winner ? r1_addr        : r0_addr;
                        cmd_wdata_reg       <= winner ? r1_wdata       : r0_wdata;
                        count_reg           <= 8'h0;
                    end
                end
                ACCESS: begin
                    // A ready response in the final wait cycle beats the timeout.
                    if (mem_ready) begin
                        rdata_reg <= mem_out;
                        fault_reg <= {mem_op_fault, mem_addr_fault, ~mem_access_fault_n};
                    end else if (timeout_hit) begin
                        rdata_reg <= 32'h0;
                        fault_reg <= 3'b001;
                    end else begin
                        count_reg <= count_reg + 8'h1;
                    end
                end
                RESP: last_grant_reg <= grant_reg;
                default: ;
            endcase
        end
    end

    assign mem_enable_n    = (state_reg != ACCESS);
    assign mem_is_write    = cmd_is_write_reg;
    assign mem_is_unsigned = cmd_is_unsigned_reg;
    assign mem_op          = cmd_op_reg;
    assign mem_addr        = cmd_addr_reg;
    assign mem_in          = cmd_wdata_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign ack_vec[gi]   = (state_reg == RESP) && (grant_reg == 1'(gi));
            assign rdata_vec[gi] = ack_vec[gi] ? rdata_reg : 32'h0;
            assign fault_vec[gi] = ack_vec[gi] ? fault_reg : 3'b000;
        end
    endgenerate

    assign r0_ack   = ack_vec[0];
    assign r1_ack   = ack_vec[1];
    assign r0_rdata = rdata_vec[0];
    assign r1_rdata = rdata_vec[1];
    assign r0_fault = fault_vec[0];
    assign r1_fault = fault_vec[1];

endmodule
